// File: rtl/nanorv32_wb_lsu_pkg.sv
// ---------------------------------------------------------------------
// nanorv32_wb_lsu_pkg : writeback/LSU op, size and FSM state encodings
// Rev 1.0
// ---------------------------------------------------------------------
`default_nettype none

package nanorv32_wb_lsu_pkg;

  localparam logic [1:0] NANORV32_WB_OP_ALU   = 2'd0;
  localparam logic [1:0] NANORV32_WB_OP_LOAD  = 2'd1;
  localparam logic [1:0] NANORV32_WB_OP_STORE = 2'd2;
  localparam logic [1:0] NANORV32_WB_OP_NOP   = 2'd3;

  localparam logic [1:0] NANORV32_MEM_SIZE_BYTE = 2'd0;
  localparam logic [1:0] NANORV32_MEM_SIZE_HALF = 2'd1;
  localparam logic [1:0] NANORV32_MEM_SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    NANORV32_WB_ST_IDLE = 2'd0,
    NANORV32_WB_ST_REQ  = 2'd1,
    NANORV32_WB_ST_WAIT = 2'd2
  } wb_state_t;

  // Size codes 2 and 3 are both treated as word accesses.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (size)
      NANORV32_MEM_SIZE_BYTE: mis = 1'b0;
      NANORV32_MEM_SIZE_HALF: mis = addr_lo[0];
      default:                mis = |addr_lo;
    endcase
    return mis;
  endfunction

endpackage

`default_nettype wire

// File: rtl/nanorv32_lsu_align.sv
// ---------------------------------------------------------------------
// nanorv32_lsu_align : byte-lane enables, store replication, load extend
// Rev 1.0
// ---------------------------------------------------------------------
`default_nettype none

module nanorv32_lsu_align
  import nanorv32_wb_lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        addr_lo,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  input  logic [DATA_W-1:0] store_data,
  input  logic [DATA_W-1:0] load_raw,
  output logic [3:0]        be,
  output logic [DATA_W-1:0] store_lanes,
  output logic [DATA_W-1:0] load_ext
);

  logic [7:0]  load_byte;
  logic [15:0] load_half;

  always_comb begin
    load_byte   = 8'(load_raw >> {addr_lo, 3'b000});
    load_half   = 16'(load_raw >> {addr_lo[1], 4'b0000});
    be          = 4'b1111;
    store_lanes = store_data;
    load_ext    = load_raw;
    case (size)
      NANORV32_MEM_SIZE_BYTE: begin
        be          = 4'b0001 << addr_lo;
        store_lanes = {4{store_data[7:0]}};
        load_ext    = is_unsigned ? {{(DATA_W-8){1'b0}}, load_byte}
                                  : {{(DATA_W-8){load_byte[7]}}, load_byte};
      end
      NANORV32_MEM_SIZE_HALF: begin
        be          = 4'b0011 << {addr_lo[1], 1'b0};
        store_lanes = {2{store_data[15:0]}};
        load_ext    = is_unsigned ? {{(DATA_W-16){1'b0}}, load_half}
                                  : {{(DATA_W-16){load_half[15]}}, load_half};
      end
      default: begin
        be          = 4'b1111;
        store_lanes = store_data;
        load_ext    = load_raw;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/nanorv32_wb_lsu.sv
// ---------------------------------------------------------------------
// nanorv32_wb_lsu : execute-to-writeback stage with data-bus load/store
// Optional: NANORV32_MISALIGN_TRAP_EN (misaligned access pulse). Rev 1.0
// ---------------------------------------------------------------------
`default_nettype none

module nanorv32_wb_lsu
  import nanorv32_wb_lsu_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int RF_ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ex_valid,
  output logic                 ex_ready,
  input  logic [1:0]           ex_op,
  input  logic [1:0]           ex_size,
  input  logic                 ex_unsigned,
  input  logic [RF_ADDR_W-1:0] ex_rd,
  input  logic [DATA_W-1:0]    alu_res,
  input  logic [DATA_W-1:0]    ex_store_data,
  output logic                 dbus_req,
  output logic                 dbus_we,
  output logic [DATA_W-1:0]    dbus_addr,
  output logic [3:0]           dbus_be,
  output logic [DATA_W-1:0]    dbus_wdata,
  input  logic                 dbus_gnt,
  input  logic                 dbus_rvalid,
  input  logic [DATA_W-1:0]    dbus_rdata,
  output logic                 rf_we,
  output logic [RF_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]    rf_wdata,
  output logic                 mem_misalign
);

  wb_state_t            state;
  logic [1:0]           addr_lo_q;
  logic [1:0]           size_q;
  logic                 unsigned_q;
  logic [RF_ADDR_W-1:0] rd_q;

  logic                 idle;
  logic                 mem_op;
  logic                 trap;
  logic [1:0]           sel_lo;
  logic [1:0]           sel_size;
  logic                 sel_unsigned;
  logic [3:0]           lane_be;
  logic [DATA_W-1:0]    lane_wdata;
  logic [DATA_W-1:0]    load_ext;

  assign idle     = (state == NANORV32_WB_ST_IDLE);
  assign ex_ready = idle;
  assign mem_op   = (ex_op == NANORV32_WB_OP_LOAD) || (ex_op == NANORV32_WB_OP_STORE);

  // The aligner sees the incoming instruction in IDLE, the latched access otherwise.
  assign sel_lo       = idle ? alu_res[1:0] : addr_lo_q;
  assign sel_size     = idle ? ex_size      : size_q;
  assign sel_unsigned = idle ? ex_unsigned  : unsigned_q;

  nanorv32_lsu_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .addr_lo     (sel_lo),
    .size        (sel_size),
    .is_unsigned (sel_unsigned),
    .store_data  (ex_store_data),
    .load_raw    (dbus_rdata),
    .be          (lane_be),
    .store_lanes (lane_wdata),
    .load_ext    (load_ext)
  );

`ifdef NANORV32_MISALIGN_TRAP_EN
  logic misalign_q;

  assign trap = is_misaligned(ex_size, alu_res[1:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= idle && ex_valid && mem_op && trap;
    end
  end

  assign mem_misalign = misalign_q;
`else
  assign trap         = 1'b0;
  assign mem_misalign = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= NANORV32_WB_ST_IDLE;
      dbus_req   <= 1'b0;
      dbus_we    <= 1'b0;
      dbus_addr  <= '0;
      dbus_be    <= 4'b0000;
      dbus_wdata <= '0;
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      addr_lo_q  <= 2'b00;
      size_q     <= NANORV32_MEM_SIZE_BYTE;
      unsigned_q <= 1'b0;
      rd_q       <= '0;
    end else begin
      rf_we <= 1'b0;
      case (state)
        NANORV32_WB_ST_IDLE: begin
          if (ex_valid) begin
            if (ex_op == NANORV32_WB_OP_ALU) begin
              rf_we    <= (ex_rd != '0);
              rf_waddr <= ex_rd;
              rf_wdata <= alu_res;
            end else if (mem_op && !trap) begin
              state      <= NANORV32_WB_ST_REQ;
              dbus_req   <= 1'b1;
              dbus_we    <= (ex_op == NANORV32_WB_OP_STORE);
              dbus_addr  <= {alu_res[DATA_W-1:2], 2'b00};
              dbus_be    <= lane_be;
              dbus_wdata <= lane_wdata;
              addr_lo_q  <= alu_res[1:0];
              size_q     <= ex_size;
              unsigned_q <= ex_unsigned;
              rd_q       <= ex_rd;
            end
          end
        end
        NANORV32_WB_ST_REQ: begin
          if (dbus_gnt) begin
            dbus_req <= 1'b0;
            state    <= dbus_we ? NANORV32_WB_ST_IDLE : NANORV32_WB_ST_WAIT;
          end
        end
        NANORV32_WB_ST_WAIT: begin
          if (dbus_rvalid) begin
            rf_we    <= (rd_q != '0);
            rf_waddr <= rd_q;
            rf_wdata <= load_ext;
            state    <= NANORV32_WB_ST_IDLE;
          end
        end
        default: state <= NANORV32_WB_ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_nanorv32_wb_lsu.sv
// ---------------------------------------------------------------------
// tb_nanorv32_wb_lsu : directed + randomized checks against a spec model
// Honours NANORV32_MISALIGN_TRAP_EN. Rev 1.0
// ---------------------------------------------------------------------
`default_nettype none

module tb_nanorv32_wb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic [1:0]  ex_op;
  logic [1:0]  ex_size;
  logic        ex_unsigned;
  logic [4:0]  ex_rd;
  logic [31:0] alu_res;
  logic [31:0] ex_store_data;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_wdata;
  logic        dbus_gnt;
  logic        dbus_rvalid;
  logic [31:0] dbus_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        mem_misalign;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  nanorv32_wb_lsu #(
    .DATA_W    (32),
    .RF_ADDR_W (5)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ex_valid      (ex_valid),
    .ex_ready      (ex_ready),
    .ex_op         (ex_op),
    .ex_size       (ex_size),
    .ex_unsigned   (ex_unsigned),
    .ex_rd         (ex_rd),
    .alu_res       (alu_res),
    .ex_store_data (ex_store_data),
    .dbus_req      (dbus_req),
    .dbus_we       (dbus_we),
    .dbus_addr     (dbus_addr),
    .dbus_be       (dbus_be),
    .dbus_wdata    (dbus_wdata),
    .dbus_gnt      (dbus_gnt),
    .dbus_rvalid   (dbus_rvalid),
    .dbus_rdata    (dbus_rdata),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .mem_misalign  (mem_misalign)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: lanes and extension derived directly from the access rules.
  function automatic logic [3:0] m_be(input logic [31:0] a, input logic [1:0] sz);
    logic [3:0] b;
    b = 4'b0000;
    if (sz == 2'd0) b[a[1:0]] = 1'b1;
    else if (sz == 2'd1) begin
      b[{a[1], 1'b0}] = 1'b1;
      b[{a[1], 1'b1}] = 1'b1;
    end else b = 4'b1111;
    return b;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] d, input logic [1:0] sz);
    if (sz == 2'd0) return {d[7:0], d[7:0], d[7:0], d[7:0]};
    if (sz == 2'd1) return {d[15:0], d[15:0]};
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] sz,
                                         input logic uns, input logic [31:0] r);
    logic [7:0]  by;
    logic [15:0] hw;
    by = r[8*a[1:0] +: 8];
    hw = r[16*a[1] +: 16];
    if (sz == 2'd0) return uns ? 32'(by) : 32'($signed(by));
    if (sz == 2'd1) return uns ? 32'(hw) : 32'($signed(hw));
    return r;
  endfunction

  function automatic logic m_trap(input logic [31:0] a, input logic [1:0] sz);
`ifdef NANORV32_MISALIGN_TRAP_EN
    if (sz == 2'd1) return a[0];
    if (sz >= 2'd2) return (a[1:0] != 2'b00);
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [1:0] sz, input logic uns,
                       input logic [4:0] rd, input logic [31:0] res, input logic [31:0] sd);
    chk("ready_before_issue", 32'(ex_ready), 32'd1);
    ex_valid = 1'b1; ex_op = op; ex_size = sz; ex_unsigned = uns;
    ex_rd = rd; alu_res = res; ex_store_data = sd;
    step();
    ex_valid = 1'b0; alu_res = $urandom; ex_store_data = $urandom;
  endtask

  task automatic do_alu(input logic [4:0] rd, input logic [31:0] res);
    issue(2'd0, 2'($urandom), 1'($urandom), rd, res, 32'($urandom));
    chk("alu_rf_we", 32'(rf_we), 32'(rd != 5'd0));
    if (rd != 5'd0) begin
      chk("alu_waddr", 32'(rf_waddr), 32'(rd));
      chk("alu_wdata", rf_wdata, res);
    end
    chk("alu_no_req", 32'(dbus_req), 32'd0);
  endtask

  task automatic do_mem(input logic is_store, input logic [1:0] sz, input logic uns,
                        input logic [4:0] rd, input logic [31:0] addr, input logic [31:0] sd,
                        input logic [31:0] rdata, input int gd, input int rvd);
    issue(is_store ? 2'd2 : 2'd1, sz, uns, rd, addr, sd);
    if (m_trap(addr, sz)) begin
      chk("trap_pulse", 32'(mem_misalign), 32'd1);
      chk("trap_no_req", 32'(dbus_req), 32'd0);
      chk("trap_no_rf", 32'(rf_we), 32'd0);
      chk("trap_ready", 32'(ex_ready), 32'd1);
      step();
      chk("trap_pulse_end", 32'(mem_misalign), 32'd0);
      return;
    end
    chk("no_misalign", 32'(mem_misalign), 32'd0);
    for (int i = 0; i <= gd; i++) begin
      chk("req_high", 32'(dbus_req), 32'd1);
      chk("req_we", 32'(dbus_we), 32'(is_store));
      chk("req_addr", dbus_addr, addr & 32'hFFFF_FFFC);
      chk("req_be", 32'(dbus_be), 32'(m_be(addr, sz)));
      if (is_store) chk("req_wdata", dbus_wdata, m_wdata(sd, sz));
      chk("req_not_ready", 32'(ex_ready), 32'd0);
      chk("req_no_rf", 32'(rf_we), 32'd0);
      if (i == gd) dbus_gnt = 1'b1;
      step();
      dbus_gnt = 1'b0;
    end
    chk("req_dropped", 32'(dbus_req), 32'd0);
    if (is_store) begin
      chk("store_done_ready", 32'(ex_ready), 32'd1);
      return;
    end
    for (int i = 0; i < rvd; i++) begin
      chk("wait_no_rf", 32'(rf_we), 32'd0);
      chk("wait_not_ready", 32'(ex_ready), 32'd0);
      step();
    end
    dbus_rvalid = 1'b1; dbus_rdata = rdata;
    step();
    dbus_rvalid = 1'b0; dbus_rdata = $urandom;
    chk("load_rf_we", 32'(rf_we), 32'(rd != 5'd0));
    if (rd != 5'd0) begin
      chk("load_waddr", 32'(rf_waddr), 32'(rd));
      chk("load_wdata", rf_wdata, m_load(addr, sz, uns, rdata));
    end
    chk("load_done_ready", 32'(ex_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; ex_valid = 1'b0; ex_op = 2'd3; ex_size = 2'd0; ex_unsigned = 1'b0;
    ex_rd = 5'd0; alu_res = 32'd0; ex_store_data = 32'd0;
    dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = 32'd0;
    step(); step();
    rst = 1'b0;

    chk("rst_ready", 32'(ex_ready), 32'd1);
    chk("rst_req", 32'(dbus_req), 32'd0);
    chk("rst_we", 32'(dbus_we), 32'd0);
    chk("rst_addr", dbus_addr, 32'd0);
    chk("rst_be", 32'(dbus_be), 32'd0);
    chk("rst_wdata", dbus_wdata, 32'd0);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_rf_wdata", rf_wdata, 32'd0);
    chk("rst_misalign", 32'(mem_misalign), 32'd0);

    do_alu(5'd5, 32'h1234_5678);
    chk("alu_const", rf_wdata, 32'h1234_5678);
    do_alu(5'd0, 32'hDEAD_BEEF);

    // Back-to-back ALU ops with ex_valid held high.
    ex_valid = 1'b1; ex_op = 2'd0;
    for (int i = 1; i <= 3; i++) begin
      ex_rd = 5'(i + 8); alu_res = 32'(i * 32'h0101_0101);
      step();
      chk("b2b_rf_we", 32'(rf_we), 32'd1);
      chk("b2b_waddr", 32'(rf_waddr), 32'(i + 8));
      chk("b2b_wdata", rf_wdata, 32'(i * 32'h0101_0101));
    end
    ex_valid = 1'b0;
    step();
    chk("b2b_end", 32'(rf_we), 32'd0);

    do_mem(1'b1, 2'd0, 1'b0, 5'd1, 32'h0000_1003, 32'h0000_00AB, 32'd0, 3, 0);
    chk("st_b_wdata_const", dbus_wdata, 32'hABAB_ABAB);
    chk("st_b_be_const", 32'(dbus_be), 32'h8);

    do_mem(1'b0, 2'd0, 1'b0, 5'd7, 32'h0000_2002, 32'd0, 32'h0080_0000, 0, 0);
    chk("ld_b_s_const", rf_wdata, 32'hFFFF_FF80);
    do_mem(1'b0, 2'd0, 1'b1, 5'd7, 32'h0000_2002, 32'd0, 32'h0080_0000, 1, 1);
    chk("ld_b_u_const", rf_wdata, 32'h0000_0080);
    do_mem(1'b0, 2'd1, 1'b0, 5'd8, 32'h0000_2002, 32'd0, 32'h8001_1234, 0, 2);
    chk("ld_h_const", rf_wdata, 32'hFFFF_8001);
    do_mem(1'b0, 2'd2, 1'b0, 5'd9, 32'h0000_2004, 32'd0, 32'hCAFE_F00D, 2, 4);
    chk("ld_w_const", rf_wdata, 32'hCAFE_F00D);

    // Reset while waiting for load data; the late rvalid must be dropped.
    issue(2'd1, 2'd2, 1'b0, 5'd10, 32'h0000_4000, 32'd0);
    dbus_gnt = 1'b1; step(); dbus_gnt = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst_wait_ready", 32'(ex_ready), 32'd1);
    dbus_rvalid = 1'b1; dbus_rdata = 32'h5555_AAAA; step(); dbus_rvalid = 1'b0;
    chk("rst_wait_no_rf", 32'(rf_we), 32'd0);
    chk("rst_wait_no_req", 32'(dbus_req), 32'd0);
    chk("rst_wait_ready2", 32'(ex_ready), 32'd1);

    do_mem(1'b0, 2'd2, 1'b0, 5'd11, 32'h0000_3002, 32'd0, 32'h0BAD_CAFE, 0, 0);
`ifndef NANORV32_MISALIGN_TRAP_EN
    chk("ld_w_mis_addr", dbus_addr, 32'h0000_3000);
    chk("ld_w_mis_be", 32'(dbus_be), 32'hF);
`endif

    for (int n = 0; n < 80; n++) begin
      logic [1:0]  op;
      logic [31:0] a;
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      if (op == 2'd0) do_alu(5'($urandom), a);
      else if (op == 2'd3) begin
        issue(2'd3, 2'($urandom), 1'($urandom), 5'($urandom), a, 32'($urandom));
        chk("nop_no_rf", 32'(rf_we), 32'd0);
        chk("nop_no_req", 32'(dbus_req), 32'd0);
      end else
        do_mem(op == 2'd2, 2'($urandom), 1'($urandom), 5'($urandom), a, $urandom,
               $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
